// File: rtl/uart_tx_word_queue.sv
// Word FIFO feeding the 4-byte UART transmitter: queues core writes and
// issues them one at a time with a start pulse, waiting for the done pulse.
module uart_tx_word_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  idle,
  output logic [31:0]           tx_sdata,
  output logic                  tx_start,
  input  logic                  tx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state;
  state_t                next_state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  push;
  logic                  pop;

  assign full = (count == FULL_COUNT);
  assign idle = (count == '0) && (state == S_IDLE);
  assign push = wr_en && !full;

  // tx_done outside S_WAIT is spurious and deliberately ignored
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A write arriving while full is dropped even if a pop frees a slot this cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_sdata <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= pop;
      if (pop) begin
        tx_sdata <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Self-checking bench for uart_tx_word_queue: a transmitter stand-in pops a
// scoreboard of expected words on every start pulse and answers with done.
module tb_uart_tx_word_queue;

  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          idle;
  logic [31:0]   tx_sdata;
  logic          tx_start;
  logic          tx_done;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];
  int            busy_cnt = 0;
  int            starts = 0;
  int            tx_lat = 12;
  logic          spurious_req = 1'b0;
  logic [31:0]   cur_word = '0;

  always #5 clk = ~clk;

  uart_tx_word_queue #(.DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .idle     (idle),
    .tx_sdata (tx_sdata),
    .tx_start (tx_start),
    .tx_done  (tx_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Transmitter stand-in: each start must match the scoreboard head; done follows tx_lat cycles later
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = spurious_req;
      if (!rstn) begin
        busy_cnt = 0;
      end else if (tx_start) begin
        starts++;
        checkOutput("start_while_busy", {31'b0, busy_cnt != 0}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_start", 32'd1, 32'd0);
        end else begin
          cur_word = exp_q.pop_front();
          checkOutput("tx_sdata", tx_sdata, cur_word);
        end
        busy_cnt = tx_lat;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          checkOutput("sdata_hold", tx_sdata, cur_word);
          tx_done = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] data, input bit keep);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = data;
    if (keep) exp_q.push_back(data);
  endtask

  task automatic releaseWrite();
    @(negedge clk);
    wr_en = 1'b0;
    #1;
  endtask

  task automatic waitTxDone();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!tx_done && n < 200);
    if (!tx_done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    #1;
    while (!(idle && busy_cnt == 0) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_idle", {31'b0, idle}, 32'd1);
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int s0;
    int n;
    rstn    = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", {31'b0, full}, 32'd0);
    checkOutput("rst_idle", {31'b0, idle}, 32'd1);
    checkOutput("rst_tx_start", {31'b0, tx_start}, 32'd0);
    checkOutput("rst_tx_sdata", tx_sdata, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    rstn = 1'b1;

    // Single word latency and byte order
    applyStimulus(32'hDEADBEEF, 1'b1);
    releaseWrite();
    checkOutput("single_count1", 32'(count), 32'd1);
    checkOutput("single_no_start_yet", {31'b0, tx_start}, 32'd0);
    checkOutput("single_not_idle", {31'b0, idle}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("single_start", {31'b0, tx_start}, 32'd1);
    checkOutput("single_count0", 32'(count), 32'd0);
    checkOutput("single_byte0", {24'b0, tx_sdata[7:0]}, 32'h000000EF);
    checkOutput("single_byte3", {24'b0, tx_sdata[31:24]}, 32'h000000DE);
    @(negedge clk);
    #1;
    checkOutput("single_pulse_width", {31'b0, tx_start}, 32'd0);
    checkOutput("single_wait_not_idle", {31'b0, idle}, 32'd0);
    waitTxDone();
    #1;
    checkOutput("single_idle_after_done", {31'b0, idle}, 32'd1);

    // Burst ordering
    s0 = starts;
    for (int i = 1; i <= 5; i++) applyStimulus(32'(i), 1'b1);
    releaseWrite();
    checkOutput("burst_count_peak", 32'(count), 32'd4);
    checkOutput("burst_full", {31'b0, full}, 32'd1);
    waitIdle();
    checkOutput("burst_starts", 32'(starts - s0), 32'd5);

    // Push and pop in the same cycle
    applyStimulus(32'hA1A1A1A1, 1'b1);
    applyStimulus(32'hB2B2B2B2, 1'b1);
    releaseWrite();
    checkOutput("pp_count_before", 32'(count), 32'd1);
    waitTxDone();
    applyStimulus(32'hC3C3C3C3, 1'b1);
    releaseWrite();
    checkOutput("pp_count_same", 32'(count), 32'd1);
    checkOutput("pp_start", {31'b0, tx_start}, 32'd1);
    waitIdle();

    // Spurious done while idle
    s0 = starts;
    @(posedge clk);
    spurious_req = 1'b1;
    @(posedge clk);
    spurious_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("spur_idle", {31'b0, idle}, 32'd1);
    checkOutput("spur_no_start", 32'(starts - s0), 32'd0);

    // Pointer wrap with continuous refill
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n = 0;
      while (full && n < 500) begin
        wr_en = 1'b0;
        @(negedge clk);
        n++;
      end
      if (full) checkOutput("wrap_full_timeout", 32'd1, 32'd0);
      wr_en   = 1'b1;
      wr_data = 32'h5000_0000 + 32'(i);
      exp_q.push_back(wr_data);
    end
    releaseWrite();
    waitIdle();
    checkOutput("wrap_starts", 32'(starts - s0), 32'd10);
    checkOutput("wrap_no_overflow", {31'b0, overflow}, 32'd0);

    // Full and overflow while a word is in flight
    s0 = starts;
    applyStimulus(32'hF0000000, 1'b1);
    releaseWrite();
    @(negedge clk);
    for (int i = 1; i <= 5; i++) applyStimulus(32'hF0000000 + 32'(i), i < 5);
    releaseWrite();
    checkOutput("ovf_count", 32'(count), 32'd4);
    checkOutput("ovf_full", {31'b0, full}, 32'd1);
    checkOutput("ovf_set", {31'b0, overflow}, 32'd1);
    waitIdle();
    checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);
    checkOutput("ovf_starts", 32'(starts - s0), 32'd5);

    // Reset while a word is in flight with three queued
    for (int i = 0; i < 4; i++) applyStimulus(32'h70000000 + 32'(i), 1'b1);
    releaseWrite();
    checkOutput("rmid_count3", 32'(count), 32'd3);
    checkOutput("rmid_busy", {31'b0, idle}, 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rmid_count0", 32'(count), 32'd0);
    checkOutput("rmid_idle", {31'b0, idle}, 32'd1);
    checkOutput("rmid_no_start", {31'b0, tx_start}, 32'd0);
    checkOutput("rmid_overflow_clr", {31'b0, overflow}, 32'd0);
    rstn = 1'b1;
    exp_q.delete();
    s0 = starts;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("rmid_quiet", 32'(starts - s0), 32'd0);
    checkOutput("rmid_still_idle", {31'b0, idle}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_word_queue.md
# uart_tx_word_queue

Upstream feeder for the 4-byte UART transmitter: buffers 32-bit words written by the core (output instruction path) in a small FIFO and hands them one at a time to the transmitter with a start pulse, waiting for the transmitter's completion pulse before issuing the next word. It decouples core stalls from serial-line speed: the core only stalls on `full`, and words leave the queue in write order.

## Interface

- `DEPTH_LOG2`, default 4: log2 of the FIFO depth, so the default depth is 16 words; legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: reset is synchronous and active-low.
- `wr_en` in 1: core write strobe; one word per cycle.
- `wr_data` in 32: word to transmit, sampled when `wr_en`=1.
- `full` out 1: count == 2^DEPTH_LOG2; combinational from count.
- `count` out DEPTH_LOG2+1: words held in the FIFO, excluding the word in flight.
- `overflow` out 1: sticky; set when a write is dropped; cleared only by reset.
- `idle` out 1: FIFO empty and no word in flight.
- `tx_sdata` out 32: word presented to the transmitter; registered; held stable from issue until done.
- `tx_start` out 1: one-cycle start pulse to the transmitter's `ready` input.
- `tx_done` in 1: the transmitter's `valid` output, a one-cycle pulse after the 4th stop bit.

## Operation

- FIFO: circular buffer with `rd_ptr` and `wr_ptr` of width DEPTH_LOG2 that wrap modulo the depth, plus a DEPTH_LOG2+1-bit `count`.
- Write behaviour:
  - Write while not full: store at `wr_ptr`, increment `wr_ptr` and `count`.
  - Write while full: dropped and `overflow` set, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
- FSM states: S_IDLE, S_WAIT.
  - S_IDLE with count>0: load `tx_sdata` from the head, pop the head (advance `rd_ptr`, decrement `count`), assert `tx_start` for exactly one cycle, go to S_WAIT.
  - S_IDLE with count==0: stay; `tx_start`=0.
  - S_WAIT: hold `tx_sdata`; on `tx_done`=1 go to S_IDLE. A word already queued is issued from S_IDLE on the following edge.
  - `tx_done` in S_IDLE is ignored (spurious); no state change.
- The transmitter's `tx_busy` is not used, because it has no reset value. Sequencing relies solely on `tx_start` and `tx_done`.
- Byte order on the line is the transmitter's: `tx_sdata[7:0]` is sent first. This block does not reorder.
- `idle` = (count==0) && state==S_IDLE.

## Timing

- Reset values: `tx_start`=0, `tx_sdata`=0, `overflow`=0, `count`=0, `full`=0, `idle`=1, pointers=0, state=S_IDLE.
- Latency from write into an empty, idle queue: `wr_en` sampled at edge E; `count`=1 after E; `tx_start`=1 during the cycle after edge E+1; `count` returns to 0 at the same edge.
- `tx_start` is never asserted on two consecutive cycles, and never while in S_WAIT.
- Back-to-back words: `tx_done` sampled at edge D → S_IDLE; `tx_start` for the next word is high after edge D+1. The minimum gap from `tx_done` to the next start is 1 cycle, which satisfies the transmitter's idle/nbite==0 acceptance condition.
- Per-word throughput is set by the transmitter (about 4×10 bit times). The queue adds 2 cycles of overhead per word.
- Reset mid-operation: all queued words and any in-flight word are discarded. The transmitter shares `rstn` and resets in the same cycle, so no `tx_done` is outstanding after reset.

## Test plan

- Single word: reset, then write 0xDEADBEEF → `tx_start` pulses 2 cycles later with `tx_sdata`=0xDEADBEEF. The line carries bytes EF, BE, AD, DE. `idle` returns to 1 one cycle after `tx_done`.
- Burst ordering: write 0x00000001..0x00000005 on consecutive cycles → `count` peaks at 4. Exactly five `tx_start` pulses occur, in order 1..5, each after the previous `tx_done`. No `tx_start` occurs during S_WAIT.
- Full/overflow (DEPTH_LOG2=2): while the first word is in flight, write 5 more → `count`=4 and `full`=1. The 5th write is dropped and `overflow`=1 (sticky). The delivered sequence omits the dropped word.
- Simultaneous push/pop: with `count`=1 and S_WAIT ending, write on the same cycle the pop occurs → `count` stays 1 and the order is preserved.
- Pointer wrap (DEPTH_LOG2=2): stream 10 words with the FIFO refilled continuously → all 10 words are delivered in order and `overflow`=0.
- Reset mid-word: assert `rstn`=0 for 1 cycle while in S_WAIT with 3 words queued → the next cycle shows `count`=0, `idle`=1, `tx_start`=0. No further `tx_start` occurs without new writes.
